// File: rtl/diamond_route_arbiter.sv
// Round-robin route arbiter for the switch diamond: throws the switch pair, clears the
// signal, and holds the route until the crossing is vacated. DIAMOND_TIMEOUT_EN adds a clear-signal timeout.
module diamond_route_arbiter #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned GUARD_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] div,
  input  logic       occ,
  output logic [3:0] grant,
  output logic [3:0] sig,
  output logic       sw_set,
  output logic       busy,
  output logic       tmo
);

  localparam logic [CNT_W-1:0] LdSettle  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LdGuard   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LdTimeout = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StThrow, StClear, StOccupied, StRelease} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_last;
  logic [3:0]       r_grant;
  logic [3:0]       r_sig;
  logic             r_sw;
  logic             r_busy;
  logic             r_tmo;

  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_found;
  logic [3:0] w_win_oh;
  logic       w_owner_req;

  // Scan upward from the slot after the last winner, wrapping modulo 4.
  always_comb begin
    w_win   = r_last;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
    w_win_oh    = 4'b0001 << w_win;
    w_owner_req = |(req & r_grant);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_last  <= 2'd3;
      r_grant <= '0;
      r_sig   <= '0;
      r_sw    <= 1'b0;
      r_busy  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!occ && w_found) begin
            r_grant <= w_win_oh;
            r_last  <= w_win;
            r_busy  <= 1'b1;
            if (div[w_win] != r_sw) begin
              r_sw    <= div[w_win];
              r_cnt   <= LdSettle;
              r_state <= StThrow;
            end else begin
              r_cnt   <= LdTimeout;
              r_sig   <= w_win_oh;
              r_state <= StClear;
            end
          end
        end
        StThrow: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!occ) begin
            r_cnt   <= LdTimeout;
            r_sig   <= r_grant;
            r_state <= StClear;
          end
        end
        StClear: begin
          if (occ) begin
            r_sig   <= '0;
            r_state <= StOccupied;
          end else if (!w_owner_req) begin
            r_sig   <= '0;
            r_cnt   <= LdGuard;
            r_state <= StRelease;
          end
`ifdef DIAMOND_TIMEOUT_EN
          else if (r_cnt == '0) begin
            r_tmo   <= 1'b1;
            r_sig   <= '0;
            r_cnt   <= LdGuard;
            r_state <= StRelease;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
`endif
        end
        StOccupied: begin
          if (!occ) begin
            r_cnt   <= LdGuard;
            r_state <= StRelease;
          end
        end
        StRelease: begin
          if (r_cnt == '0) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign grant  = r_grant;
  assign sig    = r_sig;
  assign sw_set = r_sw;
  assign busy   = r_busy;
  assign tmo    = r_tmo;

endmodule
